mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Main-memory controller directly downstream of the instruction and data caches. Accepts cacheline read requests from both caches and writeback requests from the data cache. Queues reads per source, arbitrates one read issue per cycle, and returns each cacheline after a fixed pipeline latency on the requester's receive port. Writebacks update the backing store immediately.

## Interface
Parameters:
- LATENCY, 5, cycles from read issue to response (≥1)
- MEM_LINES, 4096, cachelines in the backing store (power of 2)
- QDEPTH, 4, entries per read-request queue (power of 2, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ic_req_ren  in  1  icache read request
- ic_req_raddr  in  pptr_t  icache read address
- ic_rec_en  out  1  icache response valid
- ic_rec_addr  out  pptr_t  icache response address
- ic_rec_cacheline  out  cacheline_t  icache response data
- dc_req_ren  in  1  dcache read request
- dc_req_raddr  in  pptr_t  dcache read address
- dc_req_wen  in  1  dcache writeback request
- dc_req_waddr  in  pptr_t  writeback address
- dc_req_wcacheline  in  cacheline_t  writeback data
- dc_rec_en  out  1  dcache response valid
- dc_rec_addr  out  pptr_t  dcache response address
- dc_rec_cacheline  out  cacheline_t  dcache response data
- ovf  out  1  sticky: a read request was dropped on a full queue

## Operation
- Line index = {tag, idx} fields of the address, modulo MEM_LINES. Offset bits are ignored.
- Response address = request address with offset forced to 0.
- Store contents are not touched by rst and are initialised to zero at time 0.
- Per-source FIFO (icq, dcq), QDEPTH entries. A request is pushed at the edge ending the cycle in which ren=1.
- A FIFO that is full and not popping in the same cycle drops the push and sets ovf. A FIFO that is full and popping in the same cycle accepts the push.
- Issue, once per cycle:
  - Candidates are the nonempty FIFO heads. The winner is popped.
  - The store is read in the issue cycle and the line enters a LATENCY-deep shift pipeline tagged with its source.
  - Arbitration is fixed priority with dcache winning, or round-robin when configured.
- Pipeline exit: the tag selects ic_rec_* or dc_rec_*. rec_en is high for exactly 1 cycle. Both rec_en outputs are never high in the same cycle.
- Writeback: with dc_req_wen=1 in cycle t, the store is written at the end of cycle t.
  - A read issued in cycle t+1 or later returns the new data.
  - Reads already in the pipeline keep the old data.
- A same-cycle dc_req_ren and dc_req_wen are both accepted.
- Duplicate reads to the same line are not merged. Each read gets its own response, in issue order.
- rst clears both FIFOs, all pipeline valid bits, the round-robin pointer and ovf. Requests in flight are discarded with no response.
- Reset values: ic_rec_en=0, dc_rec_en=0, ovf=0. Address and data outputs = 0.

## Timing
- Read request in cycle t with an empty FIFO and no competitor: issued in cycle t+1, response rec_en high in cycle t+1+LATENCY.
- Each cycle lost to arbitration or queueing adds 1 cycle.
- Throughput: 1 read issue per cycle total. Writes: 1 per cycle, never stall.
- A request high in the same cycle as rst=1 is ignored.
- ovf rises in the cycle after the dropping edge and clears only on rst.

## Configuration
- MEM_CTRL_RR_ARB_EN defined:
  - On conflict, grant the source not granted at the last conflict. The pointer updates only on conflicts and resets to favour dcache first.
- Undefined: dcache always wins. An icache head waits while dcq is nonempty.

## Test plan
- LATENCY=5. ic_req_ren=1, addr 0x1234 in cycle 10 -> ic_rec_en high only in cycle 16, ic_rec_addr=0x1230, data equals the store line.
- dc_req_wen (addr 0x40, data A) and dc_req_ren (addr 0x40) in the same cycle 20 -> dc_rec_en in cycle 26 with data A.
- ic and dc reads in the same cycle, plus conflicts over 4 consecutive cycles:
  - Without macro: all dc responses come before any ic response.
  - With MEM_CTRL_RR_ARB_EN: responses alternate dc, ic, dc, ic.
- dc requests 5 lines in consecutive cycles while ic holds arbitration priority (RR build) or dcq is kept full -> 5th push dropped, ovf=1 from the next cycle, exactly 4 dc responses.
- QDEPTH dc requests, then a push in the cycle the head pops -> no drop, ovf stays 0, all responses arrive in order.
- Two reads in flight, rst in cycle 3 after issue -> no rec_en until new requests, ovf=0. The store retains earlier writebacks.

Source files
------------

// File: rtl/mem_ctrl.sv
// Main-memory controller: per-source read FIFOs, one read issue per cycle,
// fixed-latency line return, immediate writebacks. Round-robin arbitration via MEM_CTRL_RR_ARB_EN.
package mem_ctrl_pkg;
  localparam int OFFSET_W = 4;

  typedef logic [31:0]  pptr_t;
  typedef logic [127:0] cacheline_t;

  typedef enum logic {
    SRC_IC = 1'b0,
    SRC_DC = 1'b1
  } src_e;

  typedef struct packed {
    logic       v;
    src_e       src;
    pptr_t      addr;
    cacheline_t line;
  } pipe_t;
endpackage

module mem_ctrl_fifo
  import mem_ctrl_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push_i,
  input  pptr_t data_i,
  input  logic  pop_i,
  output pptr_t head_o,
  output logic  empty_o,
  output logic  drop_o
);
  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(QDEPTH);

  pptr_t          buf_q [QDEPTH];
  logic [PW-1:0]  wptr_q;
  logic [PW-1:0]  rptr_q;
  logic [PW:0]    cnt_q;
  logic [PW:0]    cnt_d;
  logic           full;
  logic           push_ok;

  assign full    = (cnt_q == FULL_CNT);
  // a full queue that pops this cycle still has room for the push
  assign push_ok = push_i && (!full || pop_i);
  assign drop_o  = push_i && full && !pop_i;
  assign empty_o = (cnt_q == '0);
  assign head_o  = buf_q[rptr_q];

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_ok, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_i)   rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) buf_q[wptr_q] <= data_i;
  end
endmodule

module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int LATENCY   = 5,
  parameter int MEM_LINES = 4096,
  parameter int QDEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ic_req_ren,
  input  pptr_t      ic_req_raddr,
  output logic       ic_rec_en,
  output pptr_t      ic_rec_addr,
  output cacheline_t ic_rec_cacheline,
  input  logic       dc_req_ren,
  input  pptr_t      dc_req_raddr,
  input  logic       dc_req_wen,
  input  pptr_t      dc_req_waddr,
  input  cacheline_t dc_req_wcacheline,
  output logic       dc_rec_en,
  output pptr_t      dc_rec_addr,
  output cacheline_t dc_rec_cacheline,
  output logic       ovf
);
  localparam int LINE_W = $clog2(MEM_LINES);

  cacheline_t  mem_q [MEM_LINES];
  pipe_t       pipe_q [LATENCY];
  pipe_t       pipe_out;

  pptr_t       ic_head;
  pptr_t       dc_head;
  logic        ic_empty;
  logic        dc_empty;
  logic        ic_drop;
  logic        dc_drop;
  logic        ic_pop;
  logic        dc_pop;
  logic        ic_v;
  logic        dc_v;

  logic        iss_v;
  src_e        iss_src;
  pptr_t       iss_addr;
  cacheline_t  iss_line;

  logic        ovf_q;
  logic        ovf_d;
  logic        unused_bits;

`ifdef MEM_CTRL_RR_ARB_EN
  // set when icache should win the next conflict
  logic        rr_q;
  logic        rr_d;
`endif

  assign unused_bits = ^{ic_req_raddr[OFFSET_W-1:0],
                         dc_req_raddr[OFFSET_W-1:0],
                         dc_req_waddr};

  mem_ctrl_fifo #(.QDEPTH(QDEPTH)) u_icq (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ic_req_ren && !rst),
    .data_i  ({ic_req_raddr[31:OFFSET_W], {OFFSET_W{1'b0}}}),
    .pop_i   (ic_pop),
    .head_o  (ic_head),
    .empty_o (ic_empty),
    .drop_o  (ic_drop)
  );

  mem_ctrl_fifo #(.QDEPTH(QDEPTH)) u_dcq (
    .clk     (clk),
    .rst     (rst),
    .push_i  (dc_req_ren && !rst),
    .data_i  ({dc_req_raddr[31:OFFSET_W], {OFFSET_W{1'b0}}}),
    .pop_i   (dc_pop),
    .head_o  (dc_head),
    .empty_o (dc_empty),
    .drop_o  (dc_drop)
  );

  assign ic_v = !ic_empty && !rst;
  assign dc_v = !dc_empty && !rst;

  always_comb begin
    iss_v   = ic_v || dc_v;
    iss_src = SRC_DC;
`ifdef MEM_CTRL_RR_ARB_EN
    rr_d = rr_q;
    if (ic_v && dc_v) begin
      iss_src = rr_q ? SRC_IC : SRC_DC;
      rr_d    = !rr_q;
    end else if (ic_v) begin
      iss_src = SRC_IC;
    end
`else
    if (!dc_v) iss_src = SRC_IC;
`endif
    dc_pop = iss_v && (iss_src == SRC_DC);
    ic_pop = iss_v && (iss_src == SRC_IC);
  end

  assign iss_addr = (iss_src == SRC_DC) ? dc_head : ic_head;
  // same-cycle writeback is not visible to this read
  assign iss_line = mem_q[iss_addr[OFFSET_W +: LINE_W]];

  always_ff @(posedge clk) begin
    if (dc_req_wen && !rst)
      mem_q[dc_req_waddr[OFFSET_W +: LINE_W]] <= dc_req_wcacheline;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{v: iss_v, src: iss_src, addr: iss_addr, line: iss_line};
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign ovf_d = ovf_q || ic_drop || dc_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

`ifdef MEM_CTRL_RR_ARB_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  assign pipe_out = pipe_q[LATENCY-1];

  assign ic_rec_en        = pipe_out.v && (pipe_out.src == SRC_IC);
  assign dc_rec_en        = pipe_out.v && (pipe_out.src == SRC_DC);
  assign ic_rec_addr      = ic_rec_en ? pipe_out.addr : '0;
  assign ic_rec_cacheline = ic_rec_en ? pipe_out.line : '0;
  assign dc_rec_addr      = dc_rec_en ? pipe_out.addr : '0;
  assign dc_rec_cacheline = dc_rec_en ? pipe_out.line : '0;
  assign ovf              = ovf_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed scenarios plus random traffic checked against
// a transaction-level queue model of the controller.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int LAT   = 5;
  localparam int LINES = 4096;
  localparam int QD    = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ic_req_ren;
  pptr_t      ic_req_raddr;
  logic       ic_rec_en;
  pptr_t      ic_rec_addr;
  cacheline_t ic_rec_cacheline;
  logic       dc_req_ren;
  pptr_t      dc_req_raddr;
  logic       dc_req_wen;
  pptr_t      dc_req_waddr;
  cacheline_t dc_req_wcacheline;
  logic       dc_rec_en;
  pptr_t      dc_rec_addr;
  cacheline_t dc_rec_cacheline;
  logic       ovf;

  always #5 clk = ~clk;

  mem_ctrl #(
    .LATENCY   (LAT),
    .MEM_LINES (LINES),
    .QDEPTH    (QD)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .ic_req_ren        (ic_req_ren),
    .ic_req_raddr      (ic_req_raddr),
    .ic_rec_en         (ic_rec_en),
    .ic_rec_addr       (ic_rec_addr),
    .ic_rec_cacheline  (ic_rec_cacheline),
    .dc_req_ren        (dc_req_ren),
    .dc_req_raddr      (dc_req_raddr),
    .dc_req_wen        (dc_req_wen),
    .dc_req_waddr      (dc_req_waddr),
    .dc_req_wcacheline (dc_req_wcacheline),
    .dc_rec_en         (dc_rec_en),
    .dc_rec_addr       (dc_rec_addr),
    .dc_rec_cacheline  (dc_rec_cacheline),
    .ovf               (ovf)
  );

  typedef struct {
    int         due;
    bit         dc;
    pptr_t      addr;
    cacheline_t line;
  } rsp_t;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  pptr_t      icq_m [$];
  pptr_t      dcq_m [$];
  cacheline_t mem_m [int];
  rsp_t       pend [$];
  bit         ovf_m = 0;
  bit         rr_ic_m = 0;
  int         last_ic_cyc = -1;
  int         last_dc_cyc = -1;
  cacheline_t last_dc_line = '0;
  int         req_c;
  cacheline_t line_a;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic int lidx(input pptr_t a);
    return int'((a >> 4) % LINES);
  endfunction

  function automatic cacheline_t rd_m(input pptr_t a);
    int k;
    k = lidx(a);
    return mem_m.exists(k) ? mem_m[k] : '0;
  endfunction

  function automatic cacheline_t rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic pptr_t rnd_addr();
    return pptr_t'(($urandom_range(0, 3) << 16) | ($urandom_range(0, 7) << 4)
                   | $urandom_range(0, 15));
  endfunction

  // check this cycle's outputs, advance the model, step one clock
  task automatic cycle();
    bit         e_ic = 0;
    bit         e_dc = 0;
    pptr_t      a_ic = '0;
    pptr_t      a_dc = '0;
    cacheline_t l_ic = '0;
    cacheline_t l_dc = '0;
    bit         iv;
    bit         dv;
    bit         g_dc;
    pptr_t      a;
    foreach (pend[i]) begin
      if (pend[i].due == cyc) begin
        if (pend[i].dc) begin
          e_dc = 1; a_dc = pend[i].addr; l_dc = pend[i].line;
        end else begin
          e_ic = 1; a_ic = pend[i].addr; l_ic = pend[i].line;
        end
      end
    end
    chk("ic_en",   ic_rec_en, e_ic);
    chk("dc_en",   dc_rec_en, e_dc);
    chk("ic_addr", ic_rec_addr, a_ic);
    chk("ic_line", ic_rec_cacheline, l_ic);
    chk("dc_addr", dc_rec_addr, a_dc);
    chk("dc_line", dc_rec_cacheline, l_dc);
    chk("ovf",     ovf, ovf_m);
    if (ic_rec_en) last_ic_cyc = cyc;
    if (dc_rec_en) begin
      last_dc_cyc  = cyc;
      last_dc_line = dc_rec_cacheline;
    end
    while (pend.size() != 0 && pend[0].due <= cyc) void'(pend.pop_front());
    if (rst) begin
      icq_m.delete();
      dcq_m.delete();
      pend.delete();
      ovf_m   = 0;
      rr_ic_m = 0;
    end else begin
      iv = (icq_m.size() != 0);
      dv = (dcq_m.size() != 0);
      if (iv || dv) begin
`ifdef MEM_CTRL_RR_ARB_EN
        if (iv && dv) begin
          g_dc    = !rr_ic_m;
          rr_ic_m = g_dc;
        end else begin
          g_dc = dv;
        end
`else
        g_dc = dv;
`endif
        a = g_dc ? dcq_m.pop_front() : icq_m.pop_front();
        pend.push_back('{cyc + LAT, g_dc, a, rd_m(a)});
      end
      if (ic_req_ren) begin
        if (icq_m.size() < QD) icq_m.push_back(ic_req_raddr & ~32'hF);
        else ovf_m = 1;
      end
      if (dc_req_ren) begin
        if (dcq_m.size() < QD) dcq_m.push_back(dc_req_raddr & ~32'hF);
        else ovf_m = 1;
      end
      if (dc_req_wen) mem_m[lidx(dc_req_waddr)] = dc_req_wcacheline;
    end
    @(posedge clk);
    #1;
    cyc++;
    rst        = 1'b0;
    ic_req_ren = 1'b0;
    dc_req_ren = 1'b0;
    dc_req_wen = 1'b0;
  endtask

  initial begin
    rst               = 1'b1;
    ic_req_ren        = 1'b0;
    ic_req_raddr      = '0;
    dc_req_ren        = 1'b0;
    dc_req_raddr      = '0;
    dc_req_wen        = 1'b0;
    dc_req_waddr      = '0;
    dc_req_wcacheline = '0;
    @(posedge clk);
    #1;
    rst = 1'b1; cycle();
    rst = 1'b1; cycle();

    while (cyc < 10) cycle();
    req_c = cyc;
    ic_req_ren = 1'b1; ic_req_raddr = 32'h1234;
    cycle();
    repeat (LAT + 2) cycle();
    chk("ic_latency", last_ic_cyc, req_c + 1 + LAT);

    while (cyc < 20) cycle();
    line_a = rnd_line();
    req_c  = cyc;
    dc_req_wen = 1'b1; dc_req_waddr = 32'h40; dc_req_wcacheline = line_a;
    dc_req_ren = 1'b1; dc_req_raddr = 32'h40;
    cycle();
    repeat (LAT + 2) cycle();
    chk("dc_latency", last_dc_cyc, req_c + 1 + LAT);
    chk("wb_same_cycle", last_dc_line, line_a);

    for (int i = 0; i < 4; i++) begin
      ic_req_ren = 1'b1; ic_req_raddr = pptr_t'(32'h100 + i * 16);
      dc_req_ren = 1'b1; dc_req_raddr = pptr_t'(32'h200 + i * 16);
      cycle();
    end
    repeat (LAT + 10) cycle();

    for (int i = 0; i < 10; i++) begin
      dc_req_ren = 1'b1; dc_req_raddr = pptr_t'(32'h800 + i * 16);
      if (i >= 1 && i <= 6) begin
        ic_req_ren = 1'b1; ic_req_raddr = pptr_t'(32'h900 + i * 16);
      end
      cycle();
    end
    repeat (LAT + 12) cycle();
    rst = 1'b1; cycle();
    repeat (3) cycle();

    ic_req_ren = 1'b1; ic_req_raddr = 32'h300;
    dc_req_ren = 1'b1; dc_req_raddr = 32'h400;
    cycle();
    cycle();
    repeat (3) cycle();
    rst = 1'b1; cycle();
    repeat (LAT + 4) cycle();
    dc_req_ren = 1'b1; dc_req_raddr = 32'h4C;
    cycle();
    repeat (LAT + 2) cycle();
    chk("store_after_rst", last_dc_line, line_a);

    for (int i = 0; i < 3000; i++) begin
      ic_req_ren   = ($urandom_range(0, 99) < 55);
      ic_req_raddr = rnd_addr();
      dc_req_ren   = ($urandom_range(0, 99) < 55);
      dc_req_raddr = rnd_addr();
      dc_req_wen   = ($urandom_range(0, 99) < 30);
      dc_req_waddr = rnd_addr();
      dc_req_wcacheline = rnd_line();
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    repeat (LAT + 4 * QD + 4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
